// File: rtl/csr_timer.sv
// Constant timer for the TCFG / TVAL / TICLR CSRs. It counts down once per clk and drives
// a sticky, registered timer-interrupt level (ti_out) that only a TICLR write can clear.
module csr_timer #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_we,
  input  logic [31:0] ticlr_wdata,
  output logic [31:0] tcfg_o,
  output logic [31:0] tval_o,
  output logic        ti_out
);

  typedef enum logic [1:0] {OFF, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] tcfg, tcfg_nxt;
  logic [TIMER_W-1:0] tval, tval_nxt;
  logic [TIMER_W-1:0] reload;
  logic               expire, clr, ti_nxt;
  logic               unused_wdata;

  assign reload       = {tcfg[TIMER_W-1:2], 2'b00};
  assign clr          = ticlr_we & ticlr_wdata[0];
  assign unused_wdata = ^{ticlr_wdata[31:1], tcfg_wdata};

  always_comb begin
    state_nxt = state;
    tcfg_nxt  = tcfg;
    tval_nxt  = tval;
    expire    = 1'b0;
    if (tcfg_we) begin
      // A config write suppresses expiry evaluation for this cycle.
      tcfg_nxt = tcfg_wdata[TIMER_W-1:0];
      if (tcfg_wdata[0]) begin
        tval_nxt  = {tcfg_wdata[TIMER_W-1:2], 2'b00};
        state_nxt = RUN;
      end else begin
        state_nxt = OFF;
      end
    end else begin
      case (state)
        RUN: begin
          if (tval != '0) begin
            tval_nxt = tval - TIMER_W'(1);
          end else begin
            expire = 1'b1;
            if (tcfg[1]) tval_nxt  = reload;
            else         state_nxt = DONE;
          end
        end
        OFF, DONE: ;
        default:   state_nxt = OFF;
      endcase
    end
  end

  // Expiry beats a simultaneous clear so no interrupt is lost.
  assign ti_nxt = expire | (ti_out & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      tcfg   <= '0;
      tval   <= '0;
      ti_out <= 1'b0;
    end else begin
      state  <= state_nxt;
      tcfg   <= tcfg_nxt;
      tval   <= tval_nxt;
      ti_out <= ti_nxt;
    end
  end

  assign tcfg_o = 32'(tcfg);
  assign tval_o = 32'(tval);

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: a cycle model checked every clk plus hand-computed
// literal expectations along the spec's scenarios.
module tb_csr_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tcfg_we;
  logic [31:0] tcfg_wdata;
  logic        ticlr_we;
  logic [31:0] ticlr_wdata;
  logic [31:0] tcfg_o, tval_o;
  logic        ti_out;

  int checks = 0;
  int errors = 0;

  csr_timer #(.TIMER_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
    .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata),
    .tcfg_o(tcfg_o), .tval_o(tval_o), .ti_out(ti_out)
  );

  always #5 clk = ~clk;

  // Model: a "counting" flag plus the register contents.
  logic [31:0] m_tcfg, m_tval;
  bit          m_counting, m_ti;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tcfg = 0; m_tval = 0; m_counting = 0; m_ti = 0;
    end else begin
      bit clr;
      clr = ticlr_we && ticlr_wdata[0];
      if (tcfg_we) begin
        m_tcfg     = tcfg_wdata;
        m_counting = tcfg_wdata[0];
        if (tcfg_wdata[0]) m_tval = tcfg_wdata & 32'hFFFF_FFFC;
        if (clr) m_ti = 0;
      end else if (m_counting && m_tval == 0) begin
        m_ti = 1;
        if (m_tcfg[1]) m_tval = m_tcfg & 32'hFFFF_FFFC;
        else           m_counting = 0;
      end else begin
        if (m_counting) m_tval = m_tval - 1;
        if (clr) m_ti = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_tcfg", tcfg_o, m_tcfg);
    chk("model_tval", tval_o, m_tval);
    chk("model_ti", {31'd0, ti_out}, {31'd0, m_ti});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tcfg_w(input logic [31:0] v);
    tcfg_we = 1'b1; tcfg_wdata = v;
    @(negedge clk);
    tcfg_we = 1'b0; tcfg_wdata = '0;
  endtask

  task automatic ticlr(input logic [31:0] v);
    ticlr_we = 1'b1; ticlr_wdata = v;
    @(negedge clk);
    ticlr_we = 1'b0; ticlr_wdata = '0;
  endtask

  task automatic lit(input string name, input logic [31:0] tv, input logic ti);
    chk({name, "_tval"}, tval_o, tv);
    chk({name, "_ti"}, {31'd0, ti_out}, {31'd0, ti});
  endtask

  initial begin
    rst_n = 1'b0; tcfg_we = 0; tcfg_wdata = 0; ticlr_we = 0; ticlr_wdata = 0;
    #1;
    chk("rst_tcfg", tcfg_o, 32'h0);
    lit("rst", 32'h0, 1'b0);
    cyc(2); rst_n = 1'b1;
    cyc(3);
    lit("idle", 32'h0, 1'b0);

    // One-shot InitVal=5
    tcfg_w(32'h15);
    chk("os_tcfg", tcfg_o, 32'h15);
    lit("os_load", 32'h14, 1'b0);
    cyc(5);  lit("os_dec", 32'h0F, 1'b0);
    cyc(15); lit("os_zero", 32'h0, 1'b0);
    cyc(1);  lit("os_fire", 32'h0, 1'b1);
    cyc(50); lit("os_hold", 32'h0, 1'b1);

    // Leave DONE via rewrite, then reset mid-run
    tcfg_w(32'h15);
    lit("rerun", 32'h14, 1'b1);
    cyc(3);  lit("rerun_dec", 32'h11, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tcfg", tcfg_o, 32'h0);
    lit("arst", 32'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    cyc(3);
    chk("post_rst_tcfg", tcfg_o, 32'h0);
    lit("post_rst", 32'h0, 1'b0);

    // Periodic InitVal=2: load 8, period 9
    tcfg_w(32'h0B);
    lit("per_load", 32'h8, 1'b0);
    cyc(8); lit("per_zero", 32'h0, 1'b0);
    cyc(1); lit("per_fire", 32'h8, 1'b1);
    ticlr(32'h1); lit("per_clr", 32'h7, 1'b0);
    cyc(7); lit("per_zero2", 32'h0, 1'b0);
    cyc(1); lit("per_fire2", 32'h8, 1'b1);
    ticlr(32'hFFFF_FFFE); lit("clr_bit0_0", 32'h7, 1'b1);
    ticlr(32'h1); lit("per_clr2", 32'h6, 1'b0);
    cyc(6); lit("per_zero3", 32'h0, 1'b0);

    // Clear in the expiry cycle: set wins
    ticlr(32'h1); lit("set_wins", 32'h8, 1'b1);

    // Rewrite and disable keep ti sticky; disable freezes tval
    tcfg_w(32'h15); lit("rw_sticky", 32'h14, 1'b1);
    cyc(8);         lit("dis_pre", 32'h0C, 1'b1);
    tcfg_w(32'h0);  lit("dis", 32'h0C, 1'b1);
    chk("dis_tcfg", tcfg_o, 32'h0);
    cyc(5);         lit("dis_hold", 32'h0C, 1'b1);
    tcfg_w(32'h15); lit("reen", 32'h14, 1'b1);
    ticlr(32'h1);   lit("reen_clr", 32'h13, 1'b0);

    // Zero load periodic: fires every clk, constant clear is overridden
    tcfg_w(32'h03); lit("z_load", 32'h0, 1'b0);
    cyc(1);         lit("z_fire", 32'h0, 1'b1);
    ticlr_we = 1'b1; ticlr_wdata = 32'h1;
    for (int i = 0; i < 5; i++) begin
      cyc(1); lit("z_clr_ovr", 32'h0, 1'b1);
    end
    ticlr_we = 1'b0; ticlr_wdata = '0;
    tcfg_w(32'h0);  lit("z_off", 32'h0, 1'b1);
    ticlr(32'h1);   lit("z_clr", 32'h0, 1'b0);
    cyc(3);         lit("z_idle", 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
